// File: rtl/rom_sequencer.sv
// rtl/rom_sequencer.sv - fetch/decode/execute controller for the instruction ROM (optional NOP stall: NOP_DELAY_EN)
module rom_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [27:0] iInstruction,
    input  logic        iHold,
    output logic [15:0] oAddress,
    output logic [7:0]  oLed,
    output logic        oLedStrobe
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LED = 4'd1;
    localparam logic [3:0] OP_STO = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_JMP = 4'd5;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1
`ifdef NOP_DELAY_EN
        , S_WAIT = 2'd2
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_pc;
    logic [27:0] r_ir;
    logic [15:0] r_regs [0:7];
    logic [7:0]  r_led;
    logic        r_strobe;

    logic [3:0]  w_op;
    logic [2:0]  w_dst;
    logic [2:0]  w_src0;
    logic [2:0]  w_src1;
    logic [15:0] w_imm16;
    logic [15:0] w_rd0;
    logic [15:0] w_rd1;
    logic        w_stall;
    logic        w_ir_load;
    logic        w_do_exec;
    logic        w_wait_done;

    assign w_op    = r_ir[27:24];
    assign w_dst   = r_ir[18:16];
    assign w_src0  = r_ir[10:8];
    assign w_src1  = r_ir[2:0];
    assign w_imm16 = r_ir[15:0];
    assign w_rd0   = r_regs[w_src0];
    assign w_rd1   = r_regs[w_src1];

`ifdef NOP_DELAY_EN
    logic [23:0] r_cnt;
    logic [23:0] w_imm24;
    assign w_imm24 = r_ir[23:0];
    // Only a real NOP with a non-zero count stalls; opcodes 6-15 never do
    assign w_stall = (w_op == OP_NOP) && (w_imm24 != 24'd0);
`else
    assign w_stall = 1'b0;
`endif

    // State register: reset wins over hold, hold freezes the machine
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= S_FETCH;
        end else if (!iHold) begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: FETCH -> EXEC -> (WAIT ->) FETCH
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_EXEC;
`ifdef NOP_DELAY_EN
            S_EXEC:  w_next_state = w_stall ? S_WAIT : S_FETCH;
            S_WAIT:  w_next_state = (r_cnt == 24'd1) ? S_FETCH : S_WAIT;
`else
            S_EXEC:  w_next_state = S_FETCH;
`endif
            default: w_next_state = S_FETCH;
        endcase
    end

    // Output decode: per-state enables for the datapath registers
    always_comb begin
        w_ir_load   = 1'b0;
        w_do_exec   = 1'b0;
        w_wait_done = 1'b0;
        case (r_state)
            S_FETCH: w_ir_load = 1'b1;
            S_EXEC:  w_do_exec = 1'b1;
`ifdef NOP_DELAY_EN
            S_WAIT:  w_wait_done = (r_cnt == 24'd1);
`endif
            default: w_ir_load = 1'b0;
        endcase
    end

    // Instruction register captures the ROM word at the FETCH edge
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_ir <= 28'd0;
        end else if (!iHold && w_ir_load) begin
            r_ir <= iInstruction;
        end
    end

    // Register file writes; sources are read before the write lands
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'd0;
            end
        end else if (!iHold && w_do_exec) begin
            case (w_op)
                OP_STO:  r_regs[w_dst] <= w_imm16;
                OP_ADD:  r_regs[w_dst] <= w_rd0 + w_rd1;
                OP_SUB:  r_regs[w_dst] <= w_rd0 - w_rd1;
                default: r_regs[w_dst] <= r_regs[w_dst];
            endcase
        end
    end

    // Program counter: jumps load imm16, a stalling NOP advances only when its wait ends
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_pc <= 16'd0;
        end else if (!iHold) begin
            if (w_do_exec) begin
                if (w_op == OP_JMP) begin
                    r_pc <= w_imm16;
                end else if (!w_stall) begin
                    r_pc <= r_pc + 16'd1;
                end
            end else if (w_wait_done) begin
                r_pc <= r_pc + 16'd1;
            end
        end
    end

`ifdef NOP_DELAY_EN
    // Stall counter: loaded at EXEC, counts down once per unheld WAIT cycle
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_cnt <= 24'd0;
        end else if (!iHold) begin
            if (w_do_exec && w_stall) begin
                r_cnt <= w_imm24;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 24'd1;
            end
        end
    end
`endif

    // LED register and its one-cycle strobe; a strobe pending under hold is kept
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_led    <= 8'h00;
            r_strobe <= 1'b0;
        end else if (!iHold) begin
            r_strobe <= w_do_exec && (w_op == OP_LED);
            if (w_do_exec && (w_op == OP_LED)) begin
                r_led <= w_rd0[7:0];
            end
        end
    end

    assign oAddress   = r_pc;
    assign oLed       = r_led;
    assign oLedStrobe = r_strobe & ~iHold;

endmodule

// File: tb/tb_rom_sequencer.sv
// tb/tb_rom_sequencer.sv - self-checking bench for rom_sequencer (follows NOP_DELAY_EN)
module tb_rom_sequencer;

`ifdef NOP_DELAY_EN
    localparam bit DLY = 1'b1;
`else
    localparam bit DLY = 1'b0;
`endif

    logic        Clock;
    logic        Reset;
    logic [27:0] iInstruction;
    logic        iHold;
    logic [15:0] oAddress;
    logic [7:0]  oLed;
    logic        oLedStrobe;

    int n_checks = 0;
    int n_err    = 0;

    logic [27:0] rom [0:31];
    logic [27:0] rom_ffff;

    rom_sequencer dut (
        .Clock(Clock),
        .Reset(Reset),
        .iInstruction(iInstruction),
        .iHold(iHold),
        .oAddress(oAddress),
        .oLed(oLed),
        .oLedStrobe(oLedStrobe)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always_comb begin
        iInstruction = (oAddress == 16'hFFFF) ? rom_ffff : rom[oAddress[4:0]];
    end

    function automatic logic [27:0] enc(input logic [3:0] op, input logic [7:0] d,
                                        input logic [7:0] s0, input logic [7:0] s1);
        return {op, d, s0, s1};
    endfunction
    function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
        return {4'd2, d, imm};
    endfunction
    function automatic logic [27:0] jmp(input logic [15:0] imm);
        return {4'd5, 8'd0, imm};
    endfunction
    function automatic logic [27:0] nop(input logic [23:0] n);
        return {4'd0, n};
    endfunction
    function automatic logic [27:0] rom_read(input logic [15:0] a);
        return (a == 16'hFFFF) ? rom_ffff : rom[a[4:0]];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 32; i++) rom[i] = nop(24'd0);
        rom_ffff = nop(24'd0);
    endtask

    // Leaves the bench in the first released cycle (FETCH at address 0)
    task automatic do_reset(input int n);
        Reset = 1'b0;
        iHold = 1'b0;
        repeat (n) tick();
        Reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  dst;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  lsrc;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t tbl [9];

    // Behavioural model state for the random program
    logic [15:0] m_r [8];
    logic [15:0] m_pc;
    logic [7:0]  m_led;
    bit          m_pend;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int c;
        Reset = 1'b0;
        iHold = 1'b0;
        clear_rom();

        tbl[0] = '{4'd3, 8'h03, 16'h0003, 16'h0005, 8'h03, 8'h08};
        tbl[1] = '{4'd3, 8'h03, 16'hFFFF, 16'h0001, 8'h03, 8'h00};
        tbl[2] = '{4'd4, 8'h03, 16'h0003, 16'h000F, 8'h03, 8'hF4};
        tbl[3] = '{4'd4, 8'h0B, 16'h1234, 16'h0025, 8'hFB, 8'h0F};
        tbl[4] = '{4'd3, 8'h03, 16'h00F0, 16'h0020, 8'h03, 8'h10};
        tbl[5] = '{4'd3, 8'h01, 16'h0040, 16'h0005, 8'h01, 8'h45};
        tbl[6] = '{4'd4, 8'h02, 16'h0010, 16'h0030, 8'h02, 8'hE0};
        tbl[7] = '{4'd7, 8'h03, 16'h0011, 16'h0022, 8'h03, 8'h00};
        tbl[8] = '{4'd3, 8'h03, 16'hAB00, 16'h00CD, 8'h03, 8'hCD};

        // Reset held 3 cycles, then first FETCH at address 0
        rom[0] = nop(24'd0);
        rom[1] = jmp(16'd1);
        Reset = 1'b0;
        repeat (3) tick();
        chk("reset_addr", {16'd0, oAddress}, 32'd0);
        chk("reset_led", {24'd0, oLed}, 32'd0);
        chk("reset_strobe", {31'd0, oLedStrobe}, 32'd0);
        Reset = 1'b1;
        #1;
        chk("first_fetch_addr", {16'd0, oAddress}, 32'd0);
        tick(); tick();
        chk("after_nop0_addr", {16'd0, oAddress}, 32'd1);

        // Reference program: STO R0,3; STO R1,15; SUB R0,R0,R1; LED R0; JMP 0
        clear_rom();
        rom[0] = sto(8'd0, 16'd3);
        rom[1] = sto(8'd1, 16'd15);
        rom[2] = enc(4'd4, 8'd0, 8'd0, 8'd1);
        rom[3] = enc(4'd1, 8'd0, 8'd0, 8'd0);
        rom[4] = jmp(16'd0);
        do_reset(3);
        for (int k = 0; k <= 10; k++) begin
            #1;
            chk($sformatf("prog_strobe_c%0d", k), {31'd0, oLedStrobe}, {31'd0, k == 8});
            if (k < 10) chk($sformatf("prog_addr_c%0d", k), {16'd0, oAddress}, k / 2);
            if (k == 8) chk("prog_led", {24'd0, oLed}, 32'hF4);
            if (k == 10) chk("prog_jmp_addr", {16'd0, oAddress}, 32'd0);
            tick();
        end

        // Table of ALU/decoding vectors
        for (int i = 0; i < 9; i++) begin
            clear_rom();
            rom[0] = sto(8'd1, tbl[i].a);
            rom[1] = sto(8'd2, tbl[i].b);
            rom[2] = enc(tbl[i].op, tbl[i].dst, 8'h01, 8'h02);
            rom[3] = enc(4'd1, 8'd0, tbl[i].lsrc, 8'd0);
            rom[4] = jmp(16'd4);
            do_reset(2);
            repeat (8) tick();
            chk($sformatf("tbl%0d_led", i), {24'd0, oLed}, {24'd0, tbl[i].exp_led});
            chk($sformatf("tbl%0d_strobe", i), {31'd0, oLedStrobe}, 32'd1);
        end

        // NOP 4000 stall length
        clear_rom();
        rom[0] = nop(24'd4000);
        rom[1] = jmp(16'd1);
        do_reset(2);
        cnt = 0;
        while (oAddress == 16'd0 && cnt < 5000) begin
            cnt++;
            tick();
        end
        chk("nop4000_cycles", cnt, DLY ? 32'd4002 : 32'd2);
        chk("nop4000_next_addr", {16'd0, oAddress}, 32'd1);

        // PC wrap from FFFF
        clear_rom();
        rom[0] = jmp(16'hFFFF);
        rom_ffff = nop(24'd0);
        do_reset(2);
        tick(); tick();
        chk("wrap_at_ffff", {16'd0, oAddress}, 32'hFFFF);
        tick(); tick();
        chk("wrap_to_zero", {16'd0, oAddress}, 32'd0);

        // Hold for 5 cycles in the middle of a 10-cycle NOP
        clear_rom();
        rom[0] = sto(8'd0, 16'h00A5);
        rom[1] = enc(4'd1, 8'd0, 8'd0, 8'd0);
        rom[2] = nop(24'd10);
        rom[3] = jmp(16'd3);
        do_reset(2);
        repeat (4) tick();
        cnt = 0;
        c = 4;
        while (oAddress == 16'd2 && cnt < 100) begin
            iHold = (c >= 7 && c <= 11);
            #1;
            chk($sformatf("hold_strobe_c%0d", c), {31'd0, oLedStrobe}, {31'd0, c == 4});
            chk($sformatf("hold_led_c%0d", c), {24'd0, oLed}, 32'hA5);
            cnt++;
            c++;
            tick();
        end
        iHold = 1'b0;
        chk("hold_stall_cycles", cnt, DLY ? 32'd17 : 32'd2);

        // Reset pulse during a 1000-cycle WAIT
        clear_rom();
        rom[0] = sto(8'd0, 16'h0077);
        rom[1] = enc(4'd1, 8'd0, 8'd0, 8'd0);
        rom[2] = nop(24'd1000);
        rom[3] = jmp(16'd3);
        do_reset(2);
        repeat (20) tick();
        chk("midwait_addr", {16'd0, oAddress}, DLY ? 32'd2 : 32'd3);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        rom[0] = sto(8'd1, 16'h0011);
        rom[1] = enc(4'd3, 8'd2, 8'd0, 8'd1);
        rom[2] = enc(4'd1, 8'd0, 8'd2, 8'd0);
        rom[3] = jmp(16'd3);
        chk("rst_wait_addr", {16'd0, oAddress}, 32'd0);
        chk("rst_wait_led", {24'd0, oLed}, 32'd0);
        chk("rst_wait_strobe", {31'd0, oLedStrobe}, 32'd0);
        tick(); tick();
        chk("rst_wait_refetch", {16'd0, oAddress}, 32'd1);
        repeat (4) tick();
        chk("rst_regs_cleared", {24'd0, oLed}, 32'h11);
        chk("rst_regs_strobe", {31'd0, oLedStrobe}, 32'd1);

        // Random program with random holds against an instruction-level model
        for (int i = 0; i < 32; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       rom[i] = nop(24'($urandom_range(0, 4)));
                1, 2:    rom[i] = enc(4'd1, 8'($urandom), 8'($urandom), 8'($urandom));
                3, 4:    rom[i] = sto(8'($urandom), 16'($urandom));
                5, 8:    rom[i] = enc(4'd3, 8'($urandom), 8'($urandom), 8'($urandom));
                6:       rom[i] = enc(4'd4, 8'($urandom), 8'($urandom), 8'($urandom));
                7:       rom[i] = jmp(16'($urandom_range(0, 31)));
                default: rom[i] = {4'($urandom_range(6, 15)), 24'($urandom)};
            endcase
        end
        rom_ffff = nop(24'd0);
        do_reset(2);
        for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
        m_pc = 16'd0;
        m_led = 8'd0;
        m_pend = 1'b0;
        for (int k = 0; k < 400; k++) begin
            logic [27:0] ins;
            logic [3:0]  op;
            int          dur;
            int          done;
            ins = rom_read(m_pc);
            op = ins[27:24];
            dur = 2 + ((DLY && op == 4'd0) ? int'(ins[23:0]) : 0);
            done = 0;
            while (done < dur) begin
                iHold = ($urandom_range(0, 7) == 0);
                #1;
                chk("rnd_addr", {16'd0, oAddress}, {16'd0, m_pc});
                chk("rnd_led", {24'd0, oLed}, {24'd0, m_led});
                chk("rnd_strobe", {31'd0, oLedStrobe}, {31'd0, m_pend && !iHold});
                if (!iHold) begin
                    m_pend = 1'b0;
                    done++;
                end
                tick();
            end
            case (op)
                4'd1: begin
                    m_led = m_r[ins[10:8]][7:0];
                    m_pend = 1'b1;
                end
                4'd2: m_r[ins[18:16]] = ins[15:0];
                4'd3: m_r[ins[18:16]] = m_r[ins[10:8]] + m_r[ins[2:0]];
                4'd4: m_r[ins[18:16]] = m_r[ins[10:8]] - m_r[ins[2:0]];
                default: ;
            endcase
            m_pc = (op == 4'd5) ? ins[15:0] : m_pc + 16'd1;
        end
        iHold = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
